regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core pipeline; next generation of the single-write, two-read register file.
- Adds configurable width, depth, read/write port counts, same-cycle write-to-read bypass, and a per-register busy scoreboard for long-latency producers such as the accelerator and load unit.
- Adds a sequential clear engine that zeroes the array one entry per cycle after reset, so the array maps to LUTRAM/BRAM.
- Adds a debug read port that feeds the seven-segment display.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, ≥ 2.
- AW, $clog2(NREGS), address width; derived, not overridden.
- NRP, 2, number of read ports.
- NWP, 2, number of write ports.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored data.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- init_done  out  1  high once the clear sequence is complete.
- rd_addr  in  NRP*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRP*XLEN  packed read data, combinational.
- rd_busy  out  NRP  scoreboard busy bit of each addressed register.
- wr_en  in  NWP  per-port write enable.
- wr_addr  in  NWP*AW  packed write addresses.
- wr_data  in  NWP*XLEN  packed write data.
- claim_en  in  1  mark a register busy (producer issued).
- claim_addr  in  AW  register to mark busy.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data, no bypass.

Behaviour:
- Reset and clear FSM, states CLEAR and READY:
  - While rst=1: state=CLEAR, clear index=0, init_done=0, all busy bits=0.
  - In CLEAR with rst=0: entry[index] is written 0 each cycle and index increments.
  - After entry NREGS-1 is cleared, the next state is READY. init_done rises exactly NREGS cycles after the cycle rst is first sampled 0.
  - READY is held until rst is reasserted. rst=1 in any state, including mid-clear, restarts at CLEAR with index=0.
- During CLEAR:
  - wr_en and claim_en are ignored.
  - rd_data, rd_busy and dbg_data are all 0.
- Writes:
  - Take effect at the rising edge; the entry holds the new value from the next cycle.
  - If several enabled ports target the same address in one cycle, the highest-index port wins.
  - If ZERO_REG=1, writes to address 0 are discarded and reads of address 0 always return 0 (bypass included).
- Reads are combinational from rd_addr.
  - BYPASS=1: if any enabled write port in the same cycle matches rd_addr[i], rd_data[i] returns that port's wr_data, highest-index match first. Otherwise it returns the stored entry.
  - BYPASS=0: rd_data[i] returns the stored entry only.
- Scoreboard, one busy bit per register:
  - claim_en sets busy[claim_addr] at the edge.
  - Any accepted write to address a clears busy[a] at the edge.
  - Claim and write to the same address in the same cycle: busy ends set (the claim is a new producer).
  - Claims of address 0 are ignored when ZERO_REG=1.
- rd_busy[i] = busy[rd_addr[i]].
  - With BYPASS=1, rd_busy[i] is forced to 0 when an enabled write to rd_addr[i] occurs in the same cycle, unless claim_en targets the same address in that cycle.
- dbg_data returns the stored entry[dbg_addr]; it is never bypassed.
- No X propagation: all state has a defined value after the clear sequence completes.

Test Plan:
1. Reset and clear: pulse rst for 2 cycles, then release with NREGS=32. init_done stays 0 for exactly 32 cycles, then goes 1. Every rd_data and dbg_data reads 0, including an entry pre-loaded with 0xDEADBEEF before the reset.
2. Mid-clear reset: assert rst at clear index 10, release 1 cycle later. init_done rises 32 cycles after the release, not earlier.
3. Write and bypass: port0 writes 0x12345678 to x5 while rd_addr[0]=5.
   - BYPASS=1: rd_data[0]=0x12345678 in the same cycle.
   - BYPASS=0: rd_data[0] shows the old value, then 0x12345678 the next cycle.
   - In both cases dbg_data for x5 updates only the next cycle.
4. Write conflict and zero register: port0 writes 0x1 and port1 writes 0x2 to x7 in one cycle; x7 then reads 0x2. A write of 0xFFFFFFFF to x0 leaves x0 reading 0, both bypassed and stored.
5. Scoreboard: claim x9, so rd_busy=1 on the next cycle. A write to x9 makes rd_busy 0 in the same cycle (BYPASS=1) and the busy bit clears at the edge. A claim and a write to x9 in the same cycle leave rd_busy=1 afterwards.
6. Writes and claims during CLEAR: write x3=0xAA and claim x3 while init_done=0. After init_done=1, x3 reads 0 and rd_busy=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, per-register busy scoreboard
// and a post-reset clear engine that zeroes one entry per cycle.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRP      = 2,
  parameter int unsigned NWP      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  typedef enum logic {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;

  logic [AW-1:0]     wr_addr_a [NWP];
  logic [XLEN-1:0]   wr_data_a [NWP];
  logic [NWP-1:0]    wr_acc;
  logic              claim_acc;
  logic              ready;

  assign ready = (state_q == StReady);

  // Writes and claims to x0 are dropped at the source when x0 is hardwired.
  always_comb begin
    for (int p = 0; p < NWP; p++) begin
      wr_addr_a[p] = wr_addr[p*AW +: AW];
      wr_data_a[p] = wr_data[p*XLEN +: XLEN];
      wr_acc[p]    = wr_en[p] && !((ZERO_REG != 0) && (wr_addr_a[p] == '0));
    end
    claim_acc = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    if (rst) begin
      state_d = StClear;
      idx_d   = '0;
      busy_d  = '0;
    end else if (state_q == StClear) begin
      mem_d[idx_q] = '0;
      idx_d        = idx_q + 1'b1;
      if (idx_q == AW'(NREGS - 1)) state_d = StReady;
    end else begin
      // Ascending port order: the highest-index port's write lands last and wins.
      for (int p = 0; p < NWP; p++) begin
        if (wr_acc[p]) begin
          mem_d[wr_addr_a[p]]  = wr_data_a[p];
          busy_d[wr_addr_a[p]] = 1'b0;
        end
      end
      // A claim in the same cycle as a write marks a new producer, so it overrides.
      if (claim_acc) busy_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    idx_q   <= idx_d;
    mem_q   <= mem_d;
    busy_q  <= busy_d;
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rval;
  logic            rbsy;
  logic            rhit;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rval    = '0;
    rbsy    = 1'b0;
    rhit    = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      ra   = rd_addr[i*AW +: AW];
      rval = mem_q[ra];
      rbsy = busy_q[ra];
      rhit = 1'b0;
      if (BYPASS != 0) begin
        for (int p = 0; p < NWP; p++) begin
          if (wr_acc[p] && (wr_addr_a[p] == ra)) begin
            rval = wr_data_a[p];
            rhit = 1'b1;
          end
        end
      end
      if (rhit && !(claim_acc && (claim_addr == ra))) rbsy = 1'b0;
      if ((ZERO_REG != 0) && (ra == '0)) rval = '0;
      if (!ready) begin
        rval = '0;
        rbsy = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = rval;
      rd_busy[i]              = rbsy;
    end
  end

  always_comb begin
    dbg_data = '0;
    if (ready && !((ZERO_REG != 0) && (dbg_addr == '0))) dbg_data = mem_q[dbg_addr];
  end

  assign init_done = ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [4:0]  dbg_addr;

  logic        init_b, init_n;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] dbg_b, dbg_n;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_b),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data_b),
    .rd_busy    (rd_busy_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_b)
  );

  regfile_mp #(.BYPASS(0)) u_dut_n (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data_n),
    .rd_busy    (rd_busy_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_n)
  );

  // Selectors for which output a scoreboard entry refers to.
  localparam int SRd0B = 0, SRd1B = 1, SBsy0B = 2, SDbgB = 3, SInitB = 4;
  localparam int SRd0N = 5, SDbgN = 6, SBsy0N = 7, SInitN = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      SRd0B:   return rd_data_b[31:0];
      SRd1B:   return rd_data_b[63:32];
      SBsy0B:  return {31'd0, rd_busy_b[0]};
      SDbgB:   return dbg_b;
      SInitB:  return {31'd0, init_b};
      SRd0N:   return rd_data_n[31:0];
      SDbgN:   return dbg_n;
      SBsy0N:  return {31'd0, rd_busy_n[0]};
      SInitN:  return {31'd0, init_n};
      default: return 32'hx;
    endcase
  endfunction

  // Monitor: outputs are combinational, so every queued expectation is due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = q.pop_front();
      a = actual(c.sel);
      n_total++;
      if (a === c.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
    end
  end

  task automatic expect_val(string name, int sel, logic [31:0] v);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = v;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    claim_en = 1'b0;
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*5 +: 5]    = 5'(a);
    wr_data[p*32 +: 32]  = d;
  endtask

  task automatic set_rd(int a0, int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  initial begin
    rst = 1'b1; idle(); wr_addr = '0; wr_data = '0; claim_addr = '0; dbg_addr = '0;
    set_rd(0, 0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 100 && !init_b; k++) tick();
    if (!init_b) begin
      n_total++;
      $display("FAIL init_timeout: got init_done=%b expected 1 within 100 cycles", init_b);
    end

    // Pre-load x5, then reset and confirm the clear wipes it.
    wr(0, 5, 32'hDEADBEEF);
    tick(); idle();
    dbg_addr = 5'd5;
    expect_val("preload_dbg", SDbgB, 32'hDEADBEEF);
    tick();
    rst = 1'b1;
    tick(); tick();
    set_rd(5, 5);
    expect_val("rst_init", SInitB, 32'd0);
    expect_val("rst_rd0", SRd0B, 32'd0);
    expect_val("rst_dbg", SDbgB, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      expect_val("clr_init_b", SInitB, (k == 32) ? 32'd1 : 32'd0);
      expect_val("clr_init_n", SInitN, (k == 32) ? 32'd1 : 32'd0);
      if (k == 3) begin
        expect_val("clr_rd0_gated", SRd0B, 32'd0);
        expect_val("clr_dbg_gated", SDbgB, 32'd0);
      end
    end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      set_rd(r, 31 - r);
      expect_val("swp_dbg", SDbgB, 32'd0);
      expect_val("swp_rd0", SRd0B, 32'd0);
      expect_val("swp_rd1", SRd1B, 32'd0);
      tick();
    end

    // Mid-clear reset at index 10, plus ignored write/claim late in the clear.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      expect_val("mid_init_early", SInitB, 32'd0);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 30) begin
        wr(0, 3, 32'hAA);
        claim_en = 1'b1; claim_addr = 5'd3;
      end
      if (k == 31) idle();
      expect_val("mid_init_b", SInitB, (k == 32) ? 32'd1 : 32'd0);
    end
    set_rd(3, 3); dbg_addr = 5'd3;
    expect_val("clrwr_rd0", SRd0B, 32'd0);
    expect_val("clrwr_busy", SBsy0B, 32'd0);
    expect_val("clrwr_dbg", SDbgB, 32'd0);

    // Write and bypass to x5.
    tick();
    wr(0, 5, 32'h12345678); set_rd(5, 5); dbg_addr = 5'd5;
    expect_val("byp_rd0_b", SRd0B, 32'h12345678);
    expect_val("byp_rd0_n", SRd0N, 32'd0);
    expect_val("byp_dbg_b", SDbgB, 32'd0);
    expect_val("byp_dbg_n", SDbgN, 32'd0);
    tick(); idle();
    expect_val("wr_rd0_b", SRd0B, 32'h12345678);
    expect_val("wr_rd0_n", SRd0N, 32'h12345678);
    expect_val("wr_dbg_b", SDbgB, 32'h12345678);
    expect_val("wr_dbg_n", SDbgN, 32'h12345678);

    // Same-address write conflict, then x0.
    tick();
    wr(0, 7, 32'h1); wr(1, 7, 32'h2); set_rd(7, 7); dbg_addr = 5'd7;
    expect_val("conf_byp_b", SRd0B, 32'h2);
    tick(); idle();
    expect_val("conf_rd0_b", SRd0B, 32'h2);
    expect_val("conf_rd1_b", SRd1B, 32'h2);
    expect_val("conf_rd0_n", SRd0N, 32'h2);
    expect_val("conf_dbg_b", SDbgB, 32'h2);
    tick();
    wr(0, 0, 32'hFFFFFFFF); set_rd(0, 7); dbg_addr = 5'd0;
    expect_val("x0_byp_b", SRd0B, 32'd0);
    tick(); idle();
    expect_val("x0_rd0_b", SRd0B, 32'd0);
    expect_val("x0_rd0_n", SRd0N, 32'd0);
    expect_val("x0_dbg_b", SDbgB, 32'd0);

    // Scoreboard on x9.
    tick();
    set_rd(9, 9); claim_en = 1'b1; claim_addr = 5'd9;
    expect_val("clm_same_cyc", SBsy0B, 32'd0);
    tick(); idle();
    expect_val("clm_busy_b", SBsy0B, 32'd1);
    expect_val("clm_busy_n", SBsy0N, 32'd1);
    tick();
    wr(1, 9, 32'h99);
    expect_val("wr_busy_fwd_b", SBsy0B, 32'd0);
    expect_val("wr_busy_fwd_n", SBsy0N, 32'd1);
    tick(); idle();
    expect_val("wr_busy_clr_b", SBsy0B, 32'd0);
    expect_val("wr_busy_clr_n", SBsy0N, 32'd0);
    tick();
    wr(0, 9, 32'h77); claim_en = 1'b1; claim_addr = 5'd9;
    expect_val("clmwr_cyc_b", SBsy0B, 32'd0);
    tick(); idle();
    expect_val("clmwr_busy_b", SBsy0B, 32'd1);
    expect_val("clmwr_busy_n", SBsy0N, 32'd1);
    expect_val("clmwr_rd0_b", SRd0B, 32'h77);
    tick();
    claim_en = 1'b1; claim_addr = 5'd0;
    tick(); idle(); set_rd(0, 9);
    expect_val("clm_x0_busy", SBsy0B, 32'd0);

    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
